uart_mmio: RTL and testbench



---
 rtl/uart_mmio.sv | 239 +++++++++++++++++++++++
 tb/tb_uart_mmio.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART slave with parametrised TX/RX FIFOs, runtime baud divisor and loopback.
// Optional level interrupt enabled by defining UART_MMIO_IRQ_EN.
module uart_mmio #(
  parameter int unsigned TX_DEPTH    = 8,
  parameter int unsigned RX_DEPTH    = 8,
  parameter int unsigned DEFAULT_DIV = 434,
  parameter logic [27:0] BASE_ADDR   = 28'h3E00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] bus_address,
  input  logic [31:0] bus_writedata,
  input  logic [3:0]  bus_byteenable,
  input  logic [4:0]  bus_burstcount,
  input  logic        bus_read,
  input  logic        bus_write,
  output logic        s_waitrequest,
  output logic [31:0] s_readdata,
  output logic        s_readdatavalid,
  output logic        s_writeresponsevalid,
  output logic [1:0]  s_response,
  output logic        irq,
  output logic        all_done,
  output logic        TX,
  input  logic        RX
);
  localparam int unsigned TXAW = $clog2(TX_DEPTH);
  localparam int unsigned RXAW = $clog2(RX_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]    tx_mem [TX_DEPTH];
  logic [7:0]    rx_mem [RX_DEPTH];
  logic [TXAW:0] tx_wr, tx_rd, tx_count, tx_free;
  logic [RXAW:0] rx_wr, rx_rd, rx_count;
  logic          tx_empty, tx_full, rx_empty, rx_full;
  logic [15:0]   div_q;
  logic [2:0]    ctrl_q;
  logic          rx_overflow, frame_error;

  state_t        tx_state, rx_state;
  logic          tx_line;
  logic [15:0]   tx_cnt, tx_div, rx_cnt, rx_div;
  logic [7:0]    tx_shift, rx_shift;
  logic [2:0]    tx_bit, rx_bit;
  logic          rx_s1, rx_s2, rx_prev, rx_in;

  logic          sel, rd, wr_sel, wr_en, tx_push, tx_err, rx_pop, tx_pop, tx_tick, rx_tick;
  logic          rx_done, rx_push, ov_set, fe_set, w1c;
  logic [31:0]   rdata_c;
  logic          unused_ok;

  assign unused_ok     = ^{bus_burstcount, bus_byteenable[3:1], bus_writedata[31:19], bus_writedata[16]};
  assign s_waitrequest = 1'b0;

  // FIFO occupancy from wrapping pointers
  assign tx_count = tx_wr - tx_rd;
  assign tx_free  = (TXAW+1)'(TX_DEPTH) - tx_count;
  assign tx_empty = (tx_wr == tx_rd);
  assign tx_full  = (tx_wr[TXAW] != tx_rd[TXAW]) && (tx_wr[TXAW-1:0] == tx_rd[TXAW-1:0]);
  assign rx_count = rx_wr - rx_rd;
  assign rx_empty = (rx_wr == rx_rd);
  assign rx_full  = (rx_wr[RXAW] != rx_rd[RXAW]) && (rx_wr[RXAW-1:0] == rx_rd[RXAW-1:0]);

  // Bus decode; lane 0 gates every write side effect
  assign sel     = (bus_address[29:2] == BASE_ADDR);
  assign rd      = sel && bus_read;
  assign wr_sel  = sel && bus_write;
  assign wr_en   = wr_sel && bus_byteenable[0];
  assign tx_push = wr_en && (bus_address[1:0] == 2'd0) && !tx_full;
  assign tx_err  = wr_en && (bus_address[1:0] == 2'd0) && tx_full;
  assign rx_pop  = rd && (bus_address[1:0] == 2'd0) && !rx_empty;
  assign w1c     = wr_en && (bus_address[1:0] == 2'd1);

  assign tx_tick = (tx_cnt == tx_div - 16'd1);
  assign tx_pop  = !tx_empty && ((tx_state == S_IDLE) || (tx_state == S_STOP && tx_tick));

  assign rx_in   = ctrl_q[0] ? tx_line : rx_s2;
  assign rx_tick = (rx_state == S_START) ? (rx_cnt == (rx_div >> 1) - 16'd1)
                                         : (rx_cnt == rx_div - 16'd1);
  assign rx_done = (rx_state == S_STOP) && rx_tick;
  assign rx_push = rx_done && rx_in && !rx_full;
  assign ov_set  = rx_done && rx_in && rx_full;
  assign fe_set  = rx_done && !rx_in;

  assign TX       = tx_line | ctrl_q[0];
  assign all_done = tx_empty && (tx_state == S_IDLE);

  always_comb begin : read_mux
    rdata_c = 32'h0;
    case (bus_address[1:0])
      2'd0:    rdata_c = rx_empty ? 32'h8000_0000 : {24'h0, rx_mem[rx_rd[RXAW-1:0]]};
      2'd1:    rdata_c = {13'h0, frame_error, rx_overflow, (tx_state != S_IDLE),
                          8'(rx_count), 8'(tx_free)};
      2'd2:    rdata_c = {16'h0, div_q};
      default: rdata_c = {29'h0, ctrl_q};
    endcase
  end

  always_ff @(posedge clk) begin : fifo_mem
    if (tx_push) tx_mem[tx_wr[TXAW-1:0]] <= bus_writedata[7:0];
    if (rx_push) rx_mem[rx_wr[RXAW-1:0]] <= rx_shift;
  end

  always_ff @(posedge clk or posedge rst) begin : bus_regs
    if (rst) begin
      s_readdata           <= 32'h0;
      s_readdatavalid      <= 1'b0;
      s_writeresponsevalid <= 1'b0;
      s_response           <= 2'b00;
      div_q                <= 16'(DEFAULT_DIV);
      ctrl_q               <= 3'b000;
      rx_overflow          <= 1'b0;
      frame_error          <= 1'b0;
      tx_wr                <= '0;
      tx_rd                <= '0;
      rx_wr                <= '0;
      rx_rd                <= '0;
    end else begin
      s_readdatavalid      <= rd;
      s_writeresponsevalid <= wr_sel;
      s_response           <= tx_err ? 2'b10 : 2'b00;
      if (rd) s_readdata <= rdata_c;
      if (wr_en && bus_address[1:0] == 2'd2)
        div_q <= (bus_writedata[15:0] < 16'd4) ? 16'd4 : bus_writedata[15:0];
      if (wr_en && bus_address[1:0] == 2'd3)
`ifdef UART_MMIO_IRQ_EN
        ctrl_q <= bus_writedata[2:0];
`else
        ctrl_q <= {2'b00, bus_writedata[0]};
`endif
      rx_overflow <= ov_set || (rx_overflow && !(w1c && bus_writedata[17]));
      frame_error <= fe_set || (frame_error && !(w1c && bus_writedata[18]));
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
    end
  end

`ifdef UART_MMIO_IRQ_EN
  always_ff @(posedge clk or posedge rst) begin : irq_reg
    if (rst) irq <= 1'b0;
    else     irq <= (ctrl_q[1] && !rx_empty) || (ctrl_q[2] && all_done) || rx_overflow || frame_error;
  end
`else
  assign irq = 1'b0;
`endif

  // Transmitter: divisor latched on each START entry
  always_ff @(posedge clk or posedge rst) begin : tx_fsm
    if (rst) begin
      tx_state <= S_IDLE;
      tx_line  <= 1'b1;
      tx_cnt   <= 16'h0;
      tx_div   <= 16'h0;
      tx_shift <= 8'h0;
      tx_bit   <= 3'd0;
    end else begin
      case (tx_state)
        S_IDLE: if (!tx_empty) begin
          tx_state <= S_START;
          tx_line  <= 1'b0;
          tx_cnt   <= 16'h0;
          tx_div   <= div_q;
          tx_shift <= tx_mem[tx_rd[TXAW-1:0]];
        end
        S_START: if (tx_tick) begin
          tx_state <= S_DATA;
          tx_line  <= tx_shift[0];
          tx_cnt   <= 16'h0;
          tx_bit   <= 3'd0;
        end else tx_cnt <= tx_cnt + 16'd1;
        S_DATA: if (tx_tick) begin
          tx_cnt   <= 16'h0;
          tx_shift <= {1'b0, tx_shift[7:1]};
          if (tx_bit == 3'd7) begin
            tx_state <= S_STOP;
            tx_line  <= 1'b1;
          end else begin
            tx_bit  <= tx_bit + 3'd1;
            tx_line <= tx_shift[1];
          end
        end else tx_cnt <= tx_cnt + 16'd1;
        S_STOP: if (tx_tick) begin
          tx_cnt <= 16'h0;
          if (!tx_empty) begin
            tx_state <= S_START;
            tx_line  <= 1'b0;
            tx_div   <= div_q;
            tx_shift <= tx_mem[tx_rd[TXAW-1:0]];
          end else tx_state <= S_IDLE;
        end else tx_cnt <= tx_cnt + 16'd1;
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  // Receiver: start bit re-checked at half a bit, then one sample per bit period
  always_ff @(posedge clk or posedge rst) begin : rx_fsm
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= 16'h0;
      rx_div   <= 16'h0;
      rx_shift <= 8'h0;
      rx_bit   <= 3'd0;
    end else begin
      rx_s1   <= RX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_in;
      case (rx_state)
        S_IDLE: if (rx_prev && !rx_in) begin
          rx_state <= S_START;
          rx_cnt   <= 16'h0;
          rx_div   <= div_q;
        end
        S_START: if (rx_tick) begin
          rx_cnt   <= 16'h0;
          rx_bit   <= 3'd0;
          rx_state <= rx_in ? S_IDLE : S_DATA;
        end else rx_cnt <= rx_cnt + 16'd1;
        S_DATA: if (rx_tick) begin
          rx_cnt   <= 16'h0;
          rx_shift <= {rx_in, rx_shift[7:1]};
          rx_bit   <= rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state <= S_STOP;
        end else rx_cnt <= rx_cnt + 16'd1;
        S_STOP: if (rx_tick) begin
          rx_cnt   <= 16'h0;
          rx_state <= S_IDLE;
        end else rx_cnt <= rx_cnt + 16'd1;
        default: rx_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_mmio.sv
// Directed-sequence bench for uart_mmio with random payloads checked against a queue/array model.
module tb_uart_mmio;
  localparam logic [27:0] BASE = 28'h3E00000;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned BIT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] bus_address;
  logic [31:0] bus_writedata;
  logic [3:0]  bus_byteenable;
  logic [4:0]  bus_burstcount;
  logic        bus_read, bus_write;
  logic        s_waitrequest, s_readdatavalid, s_writeresponsevalid;
  logic [31:0] s_readdata;
  logic [1:0]  s_response;
  logic        irq, all_done, TX, RX;

  int checks = 0;
  int errors = 0;
  logic trace_on = 1'b0;
  logic tx_trace[$];

  uart_mmio dut (
    .clk(clk), .rst(rst), .bus_address(bus_address), .bus_writedata(bus_writedata),
    .bus_byteenable(bus_byteenable), .bus_burstcount(bus_burstcount),
    .bus_read(bus_read), .bus_write(bus_write), .s_waitrequest(s_waitrequest),
    .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .s_writeresponsevalid(s_writeresponsevalid), .s_response(s_response),
    .irq(irq), .all_done(all_done), .TX(TX), .RX(RX)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (trace_on) tx_trace.push_back(TX);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] status(input int txfree, input int rxcnt, input bit busy,
                                         input bit ov, input bit fe);
    return {13'h0, fe, ov, busy, 8'(rxcnt), 8'(txfree)};
  endfunction

  task automatic bus_rd(input logic [1:0] r, output logic [31:0] d);
    @(negedge clk);
    bus_address = {BASE, r};
    bus_read = 1'b1;
    @(negedge clk);
    bus_read = 1'b0;
    check("rd_valid", 32'(s_readdatavalid), 32'd1);
    d = s_readdata;
  endtask

  task automatic bus_wr(input logic [1:0] r, input logic [31:0] d, output logic [1:0] resp);
    @(negedge clk);
    bus_address = {BASE, r};
    bus_writedata = d;
    bus_write = 1'b1;
    @(negedge clk);
    bus_write = 1'b0;
    check("wr_valid", 32'(s_writeresponsevalid), 32'd1);
    resp = s_response;
  endtask

  // Drive one 8N1 frame on the RX pin, LSB first, BIT clocks per bit
  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = fr[i];
      repeat (BIT) @(negedge clk);
    end
    RX = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  resp;
    logic [7:0]  b0, b1, rb;
    logic [7:0]  txb[10];
    logic [7:0]  rxq[$];
    int bad, pos, s, c;
    logic [7:0] got;

    rst = 1'b1; RX = 1'b1; bus_read = 1'b0; bus_write = 1'b0;
    bus_address = '0; bus_writedata = '0; bus_byteenable = 4'hF; bus_burstcount = 5'd1;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(TX), 32'd1);
    check("rst_all_done", 32'(all_done), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rvalid", 32'(s_readdatavalid), 32'd0);
    check("rst_rdata", s_readdata, 32'd0);
    check("waitrequest", 32'(s_waitrequest), 32'd0);
    rst = 1'b0;

    bus_rd(2'd1, d); check("status_reset", d, status(DEPTH, 0, 0, 0, 0));
    bus_rd(2'd2, d); check("div_reset", d, 32'd434);
    bus_rd(2'd3, d); check("ctrl_reset", d, 32'd0);

    // Divisor clamp and byte-lane gating
    bus_wr(2'd2, 32'd2, resp); bus_rd(2'd2, d); check("div_clamp", d, 32'd4);
    bus_wr(2'd2, BIT, resp); bus_rd(2'd2, d); check("div_16", d, BIT);
    bus_byteenable = 4'b1110;
    bus_wr(2'd2, 32'd100, resp);
    bus_byteenable = 4'hF;
    bus_rd(2'd2, d); check("div_be0_ignored", d, BIT);

    // Loopback: two bytes return through RX, pin held high
    bus_wr(2'd3, 32'd1, resp);
    b0 = 8'($urandom); b1 = 8'($urandom);
    bus_wr(2'd0, {24'h0, b0}, resp); check("lb_resp0", 32'(resp), 32'd0);
    bus_wr(2'd0, {24'h0, b1}, resp); check("lb_resp1", 32'(resp), 32'd0);
    bad = 0;
    for (int i = 0; i < 450; i++) begin
      @(negedge clk);
      if (TX !== 1'b1) bad++;
    end
    check("lb_pin_high", bad, 32'd0);
    bus_rd(2'd0, d); check("lb_byte0", d, {24'h0, b0});
    bus_rd(2'd0, d); check("lb_byte1", d, {24'h0, b1});
    bus_rd(2'd0, d); check("lb_empty", d, 32'h8000_0000);
    bus_wr(2'd3, 32'd0, resp);

    // Back-to-back TX fill: first byte moves to the shifter the cycle after it lands
    for (int i = 0; i < 10; i++) txb[i] = 8'($urandom);
    trace_on = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("fill_wvalid", 32'(s_writeresponsevalid), 32'd1);
        check($sformatf("fill_resp%0d", i - 1), 32'(s_response),
              ((i - 2) >= int'(DEPTH)) ? 32'd2 : 32'd0);
      end
      if (i < 10) begin
        bus_address = {BASE, 2'd0}; bus_writedata = {24'h0, txb[i]}; bus_write = 1'b1;
      end else bus_write = 1'b0;
    end
    check("fill_all_done_low", 32'(all_done), 32'd0);
    for (c = 0; c < 3000 && all_done !== 1'b1; c++) @(negedge clk);
    check("fill_all_done_rise", 32'(all_done), 32'd1);
    trace_on = 1'b0;
    pos = 0;
    for (int f = 0; f < 9; f++) begin
      s = -1;
      for (int i = pos; i < tx_trace.size(); i++) if (s < 0 && tx_trace[i] == 1'b0) s = i;
      if (s < 0 || s + 8 + BIT * 9 >= tx_trace.size()) begin
        check($sformatf("frame%0d_found", f), 32'd0, 32'd1);
        break;
      end
      for (int k = 0; k < 8; k++) got[k] = tx_trace[s + 8 + BIT * (k + 1)];
      check($sformatf("frame%0d_byte", f), 32'(got), 32'(txb[f]));
      check($sformatf("frame%0d_stop", f), 32'(tx_trace[s + 8 + BIT * 9]), 32'd1);
      pos = s + BIT * 9 + 9;
    end

    // Start-bit latency: pin drops one clock after the FIFO becomes non-empty
    rb = 8'($urandom);
    bus_wr(2'd0, {24'h0, rb}, resp);
    check("lat_tx_still_high", 32'(TX), 32'd1);
    check("lat_all_done_low", 32'(all_done), 32'd0);
    @(negedge clk);
    check("lat_start_bit", 32'(TX), 32'd0);
    for (c = 0; c < 400 && all_done !== 1'b1; c++) @(negedge clk);
    check("lat_done", 32'(all_done), 32'd1);

    // RX overflow: nine frames into an eight-deep FIFO
    for (int i = 0; i < 9; i++) begin
      rb = 8'($urandom);
      if (rxq.size() < DEPTH) rxq.push_back(rb);
      send_rx(rb, 1'b1);
    end
    repeat (10) @(negedge clk);
    bus_rd(2'd1, d); check("ovf_status", d, status(DEPTH, DEPTH, 0, 1, 0));
    bus_wr(2'd1, 32'h2_0000, resp);
    bus_rd(2'd1, d); check("ovf_w1c", d, status(DEPTH, DEPTH, 0, 0, 0));
    while (rxq.size() > 0) begin
      rb = rxq.pop_front();
      bus_rd(2'd0, d); check("rx_byte", d, {24'h0, rb});
    end
    bus_rd(2'd0, d); check("rx_drained", d, 32'h8000_0000);

    // Framing error and start-bit glitch
    send_rx(8'($urandom), 1'b0);
    repeat (10) @(negedge clk);
    bus_rd(2'd1, d); check("fe_status", d, status(DEPTH, 0, 0, 0, 1));
    bus_wr(2'd1, 32'h4_0000, resp);
    bus_rd(2'd1, d); check("fe_w1c", d, status(DEPTH, 0, 0, 0, 0));
    RX = 1'b0; repeat (2) @(negedge clk); RX = 1'b1;
    repeat (60) @(negedge clk);
    bus_rd(2'd1, d); check("glitch_status", d, status(DEPTH, 0, 0, 0, 0));

    // Unselected address: no response and no push
    @(negedge clk);
    bus_address = {BASE + 28'd1, 2'd0}; bus_writedata = 32'h5A; bus_write = 1'b1;
    @(negedge clk);
    bus_write = 1'b0; bus_read = 1'b1;
    check("unsel_no_wresp", 32'(s_writeresponsevalid), 32'd0);
    @(negedge clk);
    bus_read = 1'b0;
    check("unsel_no_rresp", 32'(s_readdatavalid), 32'd0);
    check("unsel_all_done", 32'(all_done), 32'd1);
    bus_rd(2'd1, d); check("unsel_status", d, status(DEPTH, 0, 0, 0, 0));

    // Interrupt behaviour
    bus_wr(2'd3, 32'd7, resp);
`ifdef UART_MMIO_IRQ_EN
    bus_rd(2'd3, d); check("ctrl_rw", d, 32'd7);
    check("irq_tx_empty", 32'(irq), 32'd1);
    bus_wr(2'd3, 32'd2, resp);
    @(negedge clk);
    check("irq_idle", 32'(irq), 32'd0);
    rb = 8'($urandom);
    send_rx(rb, 1'b1);
    repeat (4) @(negedge clk);
    check("irq_rx", 32'(irq), 32'd1);
    bus_rd(2'd0, d); check("irq_byte", d, {24'h0, rb});
    check("irq_hold", 32'(irq), 32'd1);
    @(negedge clk);
    check("irq_clear", 32'(irq), 32'd0);
`else
    bus_rd(2'd3, d); check("ctrl_rw", d, 32'd1);
    rb = 8'($urandom);
    bus_wr(2'd3, 32'd0, resp);
    send_rx(rb, 1'b1);
    repeat (4) @(negedge clk);
    check("irq_tied", 32'(irq), 32'd0);
    bus_rd(2'd0, d); check("irq_byte", d, {24'h0, rb});
`endif
    bus_wr(2'd3, 32'd0, resp);

    // Reset mid-frame
    bus_wr(2'd2, 32'd20, resp);
    bus_wr(2'd0, 32'h00, resp);
    bus_wr(2'd0, 32'hFF, resp);
    repeat (50) @(negedge clk);
    check("midframe_tx_low", 32'(TX), 32'd0);
    rst = 1'b1;
    #1;
    check("midrst_tx", 32'(TX), 32'd1);
    check("midrst_all_done", 32'(all_done), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    bus_rd(2'd1, d); check("midrst_status", d, status(DEPTH, 0, 0, 0, 0));
    bus_rd(2'd2, d); check("midrst_div", d, 32'd434);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
